// File: rtl/adc_frame_if.sv
// Frame-buffer read side of the ADC receiver: FWFT head, level, overflow and pop strobe.
interface adc_frame_if #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic              i_rd;
    logic [DATA_W-1:0] o_data_l;
    logic [DATA_W-1:0] o_data_r;
    logic              o_valid;
    logic              o_overflow;
    logic [LW-1:0]     o_level;

    modport master (input i_rd, output o_data_l, o_data_r, o_valid, o_overflow, o_level);
    modport slave  (output i_rd, input o_data_l, o_data_r, o_valid, o_overflow, o_level);
endinterface

// File: rtl/adc_frame_receiver.sv
// Serial audio ADC deserialiser (I2S / left-justified, mono / stereo) feeding a small
// first-word-fall-through frame FIFO, all in the BCLK domain.
module adc_frame_receiver #(
    parameter int DATA_W     = 16,
    parameter int MODE       = 0,
    parameter int STEREO     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_BCLK,
    input  logic        i_rst,
    input  logic        i_record,
    input  logic        i_ADCLRCK,
    input  logic        i_ADCDAT,
    adc_frame_if.master bus,
    output logic [2:0]  o_REC_STATE
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_SYNC = 3'd1, S_SKIP = 3'd2,
        S_SHIFT_L = 3'd3, S_SHIFT_R = 3'd4, S_WAIT_EDGE = 3'd5
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } frame_t;

    state_t            state, state_nxt;
    logic              lrck_prev, fall, rise;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt, l_word, l_word_nxt, word;
    logic              skip_r, skip_nxt;   // slot S_SKIP leads into: 0 left, 1 right
    logic              word_done, start_l, start_r, ovf_clr;
    logic              push_q, push_nxt;
    frame_t            push_frm_q, push_frm_nxt;

    frame_t            mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, level;
    logic              full, do_pop, do_push, ovf;

    assign fall = lrck_prev & ~i_ADCLRCK;
    assign rise = ~lrck_prev & i_ADCLRCK;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        shreg_nxt    = shreg;
        l_word_nxt   = l_word;
        skip_nxt     = skip_r;
        push_nxt     = 1'b0;
        push_frm_nxt = push_frm_q;
        ovf_clr      = 1'b0;
        word         = '0;
        word_done    = 1'b0;
        start_l      = 1'b0;
        start_r      = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (i_record) begin
                    state_nxt = S_SYNC;
                    ovf_clr   = 1'b1;
                end
            end
            S_SYNC: start_l = fall;
            S_SKIP: begin
                shreg_nxt = {{(DATA_W-1){1'b0}}, i_ADCDAT};
                cnt_nxt   = CW'(1);
                state_nxt = skip_r ? S_SHIFT_R : S_SHIFT_L;
            end
            S_SHIFT_L, S_SHIFT_R: begin
                if (fall || rise) begin
                    // Short slot: left-align what arrived, the edge bit belongs to the next slot.
                    word      = shreg << (CW'(DATA_W) - cnt);
                    word_done = 1'b1;
                    state_nxt = S_WAIT_EDGE;
                    start_l   = fall;
                    start_r   = (STEREO != 0) && rise;
                end else begin
                    shreg_nxt = {shreg[DATA_W-2:0], i_ADCDAT};
                    cnt_nxt   = cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        word      = shreg_nxt;
                        word_done = 1'b1;
                        state_nxt = S_WAIT_EDGE;
                    end
                end
            end
            S_WAIT_EDGE: begin
                start_l = fall;
                start_r = (STEREO != 0) && rise;
            end
            default: state_nxt = S_IDLE;
        endcase

        if (word_done) begin
            if (state == S_SHIFT_R) begin
                push_nxt     = 1'b1;
                push_frm_nxt = {l_word, word};
            end else if (STEREO == 0) begin
                push_nxt     = 1'b1;
                push_frm_nxt = {word, {DATA_W{1'b0}}};
            end else begin
                l_word_nxt = word;
            end
        end

        if (start_l || start_r) begin
            skip_nxt = start_r;
            if (MODE == 0) begin
                state_nxt = S_SKIP;
            end else begin
                shreg_nxt = {{(DATA_W-1){1'b0}}, i_ADCDAT};
                cnt_nxt   = CW'(1);
                state_nxt = start_r ? S_SHIFT_R : S_SHIFT_L;
            end
        end

        if (!i_record && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            lrck_prev  <= 1'b1;
            cnt        <= '0;
            shreg      <= '0;
            l_word     <= '0;
            skip_r     <= 1'b0;
            push_q     <= 1'b0;
            push_frm_q <= '0;
        end else begin
            state      <= state_nxt;
            lrck_prev  <= i_ADCLRCK;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            l_word     <= l_word_nxt;
            skip_r     <= skip_nxt;
            push_q     <= push_nxt;
            push_frm_q <= push_frm_nxt;
        end
    end

    // Frame FIFO: a pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = bus.i_rd && (level != '0);
    assign do_push = push_q && (!full || do_pop);

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (ovf_clr)                ovf <= 1'b0;
            else if (push_q && !do_push) ovf <= 1'b1;
        end
    end

    always_ff @(posedge i_BCLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_frm_q;
    end

    assign bus.o_valid    = (level != '0);
    assign bus.o_level    = level;
    assign bus.o_overflow = ovf;
    assign bus.o_data_l   = bus.o_valid ? mem[rd_ptr[AW-1:0]].l : '0;
    assign bus.o_data_r   = bus.o_valid ? mem[rd_ptr[AW-1:0]].r : '0;
    assign o_REC_STATE    = state;
endmodule

// File: tb/tb_adc_frame_receiver.sv
// Directed bench: three receiver configurations (I2S stereo 16b, LJ stereo 24b, I2S mono 16b)
// driven slot by slot, outputs checked with immediate assertions.
module tb_adc_frame_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rec  [3];
    logic        lrck [3];
    logic        dat  [3];
    logic        rd   [3];
    logic [2:0]  st   [3];
    logic [31:0] vld  [3];
    logic [31:0] dl   [3];
    logic [31:0] dr   [3];
    logic [31:0] lvl  [3];
    logic [31:0] ovf  [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    adc_frame_if #(.DATA_W(16), .FIFO_DEPTH(4)) if0 ();
    adc_frame_if #(.DATA_W(24), .FIFO_DEPTH(4)) if1 ();
    adc_frame_if #(.DATA_W(16), .FIFO_DEPTH(4)) if2 ();

    adc_frame_receiver #(.DATA_W(16), .MODE(0), .STEREO(1), .FIFO_DEPTH(4)) dut0 (
        .i_BCLK(clk), .i_rst(rst), .i_record(rec[0]), .i_ADCLRCK(lrck[0]),
        .i_ADCDAT(dat[0]), .bus(if0), .o_REC_STATE(st[0]));
    adc_frame_receiver #(.DATA_W(24), .MODE(1), .STEREO(1), .FIFO_DEPTH(4)) dut1 (
        .i_BCLK(clk), .i_rst(rst), .i_record(rec[1]), .i_ADCLRCK(lrck[1]),
        .i_ADCDAT(dat[1]), .bus(if1), .o_REC_STATE(st[1]));
    adc_frame_receiver #(.DATA_W(16), .MODE(0), .STEREO(0), .FIFO_DEPTH(4)) dut2 (
        .i_BCLK(clk), .i_rst(rst), .i_record(rec[2]), .i_ADCLRCK(lrck[2]),
        .i_ADCDAT(dat[2]), .bus(if2), .o_REC_STATE(st[2]));

    assign if0.i_rd = rd[0];
    assign if1.i_rd = rd[1];
    assign if2.i_rd = rd[2];
    assign vld[0] = {31'b0, if0.o_valid};
    assign vld[1] = {31'b0, if1.o_valid};
    assign vld[2] = {31'b0, if2.o_valid};
    assign dl[0]  = {16'b0, if0.o_data_l};
    assign dl[1]  = {8'b0,  if1.o_data_l};
    assign dl[2]  = {16'b0, if2.o_data_l};
    assign dr[0]  = {16'b0, if0.o_data_r};
    assign dr[1]  = {8'b0,  if1.o_data_r};
    assign dr[2]  = {16'b0, if2.o_data_r};
    assign lvl[0] = {29'b0, if0.o_level};
    assign lvl[1] = {29'b0, if1.o_level};
    assign lvl[2] = {29'b0, if2.o_level};
    assign ovf[0] = {31'b0, if0.o_overflow};
    assign ovf[1] = {31'b0, if1.o_overflow};
    assign ovf[2] = {31'b0, if2.o_overflow};

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One BCLK: drive lrck/data, let the posedge sample them, settle 1 time unit.
    task automatic cyc(int k, logic lr, logic b);
        lrck[k] = lr;
        dat[k]  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pop(int k);
        rd[k] = 1'b1;
        @(posedge clk);
        #1;
        rd[k] = 1'b0;
    endtask

    // One LRCK slot; bits outside the word are driven 1 as garbage.
    task automatic slot(int k, logic lr, logic [31:0] w, int dw, int len, bit lj,
                        int pop_at, bit chk_lat);
        int idx;
        int lat_c;
        logic b;
        lat_c = lj ? dw : dw + 1;
        for (int c = 0; c < len; c++) begin
            idx = lj ? c : c - 1;
            b   = (idx >= 0 && idx < dw) ? w[dw-1-idx] : 1'b1;
            rd[k] = (c == pop_at);
            cyc(k, lr, b);
            rd[k] = 1'b0;
            if (chk_lat && c == lat_c - 1) chk("valid_before_push", vld[k], 32'd0);
            if (chk_lat && c == lat_c)     chk("valid_after_push", vld[k], 32'd1);
        end
    endtask

    task automatic frame(int k, logic [31:0] l, logic [31:0] r, int dw, int len, bit lj);
        slot(k, 1'b0, l, dw, len, lj, -1, 1'b0);
        slot(k, 1'b1, r, dw, len, lj, -1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rec[k] = 1'b0; lrck[k] = 1'b1; dat[k] = 1'b0; rd[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", vld[0], 32'd0);
        chk("rst_level", lvl[0], 32'd0);
        chk("rst_ovf", ovf[0], 32'd0);
        chk("rst_data_l", dl[0], 32'd0);
        chk("rst_state", {29'b0, st[0]}, 32'd0);
        rst = 1'b0;

        // I2S stereo 16b: first frame, push latency, FWFT head
        rec[0] = 1'b1;
        cyc(0, 1'b1, 1'b0);
        cyc(0, 1'b1, 1'b0);
        chk("sync_state", {29'b0, st[0]}, 32'd1);
        slot(0, 1'b0, 32'h8001, 16, 32, 1'b0, -1, 1'b0);
        slot(0, 1'b1, 32'h7FFE, 16, 32, 1'b0, -1, 1'b1);
        chk("f1_data_l", dl[0], 32'h8001);
        chk("f1_data_r", dr[0], 32'h7FFE);
        chk("f1_level", lvl[0], 32'd1);
        chk("f1_state_wait", {29'b0, st[0]}, 32'd5);

        // Overflow: frames 2..6 with no reads, 5 and 6 dropped
        for (int i = 2; i <= 6; i++)
            frame(0, 32'h1000 + i, 32'h2000 + i, 16, 32, 1'b0);
        chk("ovf_level", lvl[0], 32'd4);
        chk("ovf_flag", ovf[0], 32'd1);
        chk("ovf_head_l", dl[0], 32'h8001);
        chk("ovf_head_r", dr[0], 32'h7FFE);

        // Full FIFO, push and pop in the same cycle
        slot(0, 1'b0, 32'h1007, 16, 32, 1'b0, -1, 1'b0);
        slot(0, 1'b1, 32'h2007, 16, 32, 1'b0, 17, 1'b0);
        chk("pushpop_level", lvl[0], 32'd4);
        chk("pop_head2_r", dr[0], 32'h2002);
        chk("pop_head2", dl[0], 32'h1002);
        pop(0);
        chk("pop_head3", dl[0], 32'h1003);
        pop(0);
        chk("pop_head4", dl[0], 32'h1004);
        pop(0);
        chk("pop_head7", dl[0], 32'h1007);
        chk("pop_head7_r", dr[0], 32'h2007);
        pop(0);
        chk("pop_empty", vld[0], 32'd0);
        pop(0);
        chk("pop_empty_level", lvl[0], 32'd0);

        // Record drop mid-left slot, then resync
        frame(0, 32'h1008, 32'h2008, 16, 32, 1'b0);
        for (int c = 0; c < 5; c++) cyc(0, 1'b0, 1'b1);
        rec[0] = 1'b0;
        cyc(0, 1'b0, 1'b1);
        chk("drop_state", {29'b0, st[0]}, 32'd0);
        chk("drop_level", lvl[0], 32'd1);
        chk("drop_ovf_kept", ovf[0], 32'd1);
        chk("drop_head", dl[0], 32'h1008);
        rec[0] = 1'b1;
        cyc(0, 1'b0, 1'b1);
        chk("rearm_state", {29'b0, st[0]}, 32'd1);
        chk("rearm_ovf_clr", ovf[0], 32'd0);
        for (int c = 0; c < 20; c++) cyc(0, 1'b0, 1'b1);
        slot(0, 1'b1, 32'h0, 16, 32, 1'b0, -1, 1'b0);
        chk("resync_no_push", lvl[0], 32'd1);
        frame(0, 32'h1009, 32'h2009, 16, 32, 1'b0);
        chk("resync_level", lvl[0], 32'd2);
        chk("resync_head", dl[0], 32'h1008);

        // LJ stereo 24b with garbage tail, then a short 16-bit slot frame
        rec[1] = 1'b1;
        cyc(1, 1'b1, 1'b0);
        cyc(1, 1'b1, 1'b0);
        frame(1, 32'h123456, 32'hABCDEF, 24, 32, 1'b1);
        chk("lj_level1", lvl[1], 32'd1);
        chk("lj_data_l", dl[1], 32'h123456);
        chk("lj_data_r", dr[1], 32'hABCDEF);
        frame(1, 32'h123456, 32'hABCDEF, 24, 16, 1'b1);
        frame(1, 32'h0F0F0F, 32'h707070, 24, 32, 1'b1);
        chk("lj_level3", lvl[1], 32'd3);
        pop(1);
        chk("short_l", dl[1], 32'h123400);
        chk("short_r", dr[1], 32'hABCD00);
        pop(1);
        chk("lj3_l", dl[1], 32'h0F0F0F);
        chk("lj3_r", dr[1], 32'h707070);

        // I2S mono 16b: right slot content ignored, right output zero
        rec[2] = 1'b1;
        cyc(2, 1'b1, 1'b0);
        cyc(2, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++)
            frame(2, i, 32'hFFFF, 16, 32, 1'b0);
        chk("mono_level", lvl[2], 32'd3);
        chk("mono_r_zero", dr[2], 32'd0);
        chk("mono_pop1", dl[2], 32'd1);
        pop(2);
        chk("mono_pop2", dl[2], 32'd2);
        pop(2);
        chk("mono_pop3", dl[2], 32'd3);
        pop(2);
        chk("mono_empty", vld[2], 32'd0);

        // Async reset mid-right slot with two entries held
        slot(0, 1'b0, 32'h100A, 16, 32, 1'b0, -1, 1'b0);
        for (int c = 0; c < 10; c++) cyc(0, 1'b1, 1'b1);
        chk("prerst_level", lvl[0], 32'd2);
        chk("prerst_state", {29'b0, st[0]}, 32'd4);
        rst = 1'b1;
        #2;
        chk("arst_valid", vld[0], 32'd0);
        chk("arst_level", lvl[0], 32'd0);
        chk("arst_data_l", dl[0], 32'd0);
        chk("arst_data_r", dr[0], 32'd0);
        chk("arst_state", {29'b0, st[0]}, 32'd0);
        chk("arst_ovf", ovf[0], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
